// File: rtl/fpga_bootrom_bus_adapter_if.sv
// Interconnect-side bus of the boot ROM adapter: req/gnt request channel and
// valid/ready response channel.
interface fpga_bootrom_bus_adapter_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) ();
    logic                  req;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  gnt;
    logic                  rvalid;
    logic                  rready;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  err;

    // Interconnect side issuing requests and consuming responses.
    modport master (
        output req, we, addr, rready,
        input  gnt, rvalid, rdata, err
    );

    // Adapter side.
    modport slave (
        input  req, we, addr, rready,
        output gnt, rvalid, rdata, err
    );
endinterface

// File: rtl/fpga_bootrom_bus_adapter.sv
// Boot ROM bus adapter: maps interconnect byte addresses onto ROM word indices,
// tracks the ROM's one-cycle read latency and buffers responses in a small FIFO
// so that response back-pressure never drops data. Writes and out-of-range reads
// complete with an error response and zero data.
module fpga_bootrom_bus_adapter #(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = ADDR_WIDTH'(32'h1A00_0000),
    parameter int unsigned           ROM_WORDS  = 128,
    parameter int unsigned           ROM_AW     = 7,
    parameter int unsigned           RESP_DEPTH = 3
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    fpga_bootrom_bus_adapter_if.slave     bus,
    output logic                          rom_cen_o,
    output logic [ROM_AW-1:0]             rom_addr_o,
    input  logic [DATA_WIDTH-1:0]         rom_q_i
);
    localparam int unsigned PTR_W = $clog2(RESP_DEPTH);
    localparam int unsigned CNT_W = $clog2(RESP_DEPTH + 1);

    // Response FIFO storage and pointers.
    logic [DATA_WIDTH-1:0] mem_data_q [RESP_DEPTH];
    logic [DATA_WIDTH-1:0] mem_data_d [RESP_DEPTH];
    logic [RESP_DEPTH-1:0] mem_err_q, mem_err_d;
    logic [PTR_W-1:0]      wptr_q, wptr_d;
    logic [PTR_W-1:0]      rptr_q, rptr_d;
    logic [CNT_W-1:0]      count_q, count_d;

    // One entry for the access whose ROM data arrives next cycle.
    logic                  inflight_q, inflight_d;
    logic                  infl_err_q, infl_err_d;
    logic [ROM_AW-1:0]     rom_addr_q, rom_addr_d;

    logic [ADDR_WIDTH-1:0] offset;
    logic [ADDR_WIDTH-1:0] idx;
    logic                  in_range;
    logic [CNT_W:0]        used;
    logic                  gnt;
    logic                  accept;
    logic                  rom_rd;
    logic                  rvalid;
    logic                  push;
    logic                  pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RESP_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Address decode, credit-based grant and ROM port drive.
    always_comb begin
        // An address below BASE_ADDR wraps to a huge index and falls out of range.
        offset     = bus.addr - BASE_ADDR;
        idx        = offset >> 2;
        in_range   = idx < ADDR_WIDTH'(ROM_WORDS);
        // Grant is a pure function of registered state: every accepted request
        // owns a FIFO slot, whether still inflight or already buffered.
        used       = {1'b0, count_q} + (CNT_W + 1)'(inflight_q);
        gnt        = used < (CNT_W + 1)'(RESP_DEPTH);
        accept     = bus.req && gnt;
        rom_rd     = accept && !bus.we && in_range;
        rom_cen_o  = !rom_rd;
        rom_addr_o = rom_rd ? idx[ROM_AW-1:0] : rom_addr_q;
        rom_addr_d = rom_addr_o;
        inflight_d = accept;
        infl_err_d = accept && !rom_rd;
    end

    // Response FIFO next state: push the inflight entry, pop on handshake.
    always_comb begin
        mem_data_d = mem_data_q;
        mem_err_d  = mem_err_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        count_d    = count_q;
        rvalid     = count_q != '0;
        push       = inflight_q;
        pop        = rvalid && bus.rready;
        if (push) begin
            mem_data_d[wptr_q] = infl_err_q ? '0 : rom_q_i;
            mem_err_d[wptr_q]  = infl_err_q;
            wptr_d             = ptr_inc(wptr_q);
        end
        if (pop) begin
            rptr_d = ptr_inc(rptr_q);
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    // Bus outputs: head of FIFO, forced to zero while empty.
    always_comb begin
        bus.gnt    = gnt;
        bus.rvalid = rvalid;
        bus.rdata  = rvalid ? mem_data_q[rptr_q] : '0;
        bus.err    = rvalid ? mem_err_q[rptr_q] : 1'b0;
    end

    // State registers; reset discards all pending and buffered responses.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_data_q <= '{default: '0};
            mem_err_q  <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            inflight_q <= 1'b0;
            infl_err_q <= 1'b0;
            rom_addr_q <= '0;
        end else begin
            mem_data_q <= mem_data_d;
            mem_err_q  <= mem_err_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            infl_err_q <= infl_err_d;
            rom_addr_q <= rom_addr_d;
        end
    end
endmodule

// File: tb/tb_fpga_bootrom_bus_adapter.sv
// Self-checking bench for fpga_bootrom_bus_adapter against a queue-based
// response model.
module tb_fpga_bootrom_bus_adapter;
    localparam logic [31:0] BASE = 32'h1A00_0000;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        rom_cen;
    logic [6:0]  rom_addr;
    logic [31:0] rom_q = '0;

    fpga_bootrom_bus_adapter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    fpga_bootrom_bus_adapter #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .BASE_ADDR  (32'h1A00_0000),
        .ROM_WORDS  (128),
        .ROM_AW     (7),
        .RESP_DEPTH (3)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .bus        (bus),
        .rom_cen_o  (rom_cen),
        .rom_addr_o (rom_addr),
        .rom_q_i    (rom_q)
    );

    always #5 clk = ~clk;

    // Boot ROM model: word idx holds 0xC0DE0000 | idx, registered read.
    always @(posedge clk) if (!rom_cen) rom_q <= 32'hC0DE0000 | {25'd0, rom_addr};

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          age;
    } resp_t;

    resp_t       mq[$];
    logic [6:0]  m_raddr;
    int          errors = 0;
    int          checks = 0;

    logic        exp_gnt, exp_cen, exp_rvalid, exp_err;
    logic [6:0]  exp_raddr;
    logic [31:0] exp_rdata;
    logic        obs_gnt, obs_cen, obs_rvalid, obs_err;
    logic [6:0]  obs_raddr;
    logic [31:0] obs_rdata;

    function automatic logic [42:0] obs_vec();
        return {obs_gnt, obs_cen, obs_raddr, obs_rvalid, obs_err, obs_rdata};
    endfunction

    function automatic logic [42:0] exp_vec();
        return {exp_gnt, exp_cen, exp_raddr, exp_rvalid, exp_err, exp_rdata};
    endfunction

    // One bus cycle: drive inputs, compute model expectations, sample the DUT,
    // then advance the model across the clock edge.
    task automatic do_cycle(input logic r, input logic w, input logic [31:0] a,
                            input logic rr);
        logic [31:0] idx;
        logic        in_range, rd;
        resp_t       e;
        @(negedge clk);
        bus.req = r; bus.we = w; bus.addr = a; bus.rready = rr;
        #1;
        idx        = (a - BASE) >> 2;
        in_range   = idx < 32'd128;
        // Every accepted, not yet consumed request holds one of 3 slots.
        exp_gnt    = mq.size() < 3;
        exp_rvalid = (mq.size() > 0) && (mq[0].age >= 1);
        exp_rdata  = exp_rvalid ? mq[0].data : 32'd0;
        exp_err    = exp_rvalid ? mq[0].err : 1'b0;
        rd         = r && exp_gnt && !w && in_range;
        exp_cen    = !rd;
        exp_raddr  = rd ? idx[6:0] : m_raddr;
        obs_gnt    = bus.gnt;
        obs_cen    = rom_cen;
        obs_raddr  = rom_addr;
        obs_rvalid = bus.rvalid;
        obs_err    = bus.err;
        obs_rdata  = bus.rdata;
        @(posedge clk);
        for (int i = 0; i < mq.size(); i++) mq[i].age = mq[i].age + 1;
        if (exp_rvalid && rr) void'(mq.pop_front());
        if (r && exp_gnt) begin
            e.err  = w || !in_range;
            e.data = e.err ? 32'd0 : (32'hC0DE0000 | idx);
            e.age  = 0;
            mq.push_back(e);
        end
        if (rd) m_raddr = idx[6:0];
    endtask

    task automatic test_reset;
        for (int i = 0; i < 2; i++) begin
            do_cycle(1'b0, 1'b0, 32'd0, 1'b1);
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL reset_state: got %h want %h", obs_vec(), exp_vec());
            end
            checks++;
        end
    endtask

    task automatic test_single_read;
        do_cycle(1'b1, 1'b0, 32'h1A00_0010, 1'b1);
        if (obs_cen !== 1'b0 || obs_raddr !== 7'd4) begin
            errors++;
            $display("FAIL single_rom_port: got cen=%b addr=%0d want cen=0 addr=4",
                     obs_cen, obs_raddr);
        end
        checks++;
        do_cycle(1'b0, 1'b0, 32'd0, 1'b1);
        if (obs_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL single_early: got rvalid=%b want 0", obs_rvalid);
        end
        checks++;
        do_cycle(1'b0, 1'b0, 32'd0, 1'b1);
        if (obs_rvalid !== 1'b1 || obs_rdata !== 32'hC0DE0004 || obs_err !== 1'b0) begin
            errors++;
            $display("FAIL single_resp: got v=%b d=%h e=%b want v=1 d=c0de0004 e=0",
                     obs_rvalid, obs_rdata, obs_err);
        end
        checks++;
        for (int i = 0; i < 3; i++) begin
            do_cycle(1'b0, 1'b0, 32'd0, 1'b1);
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL single_drain: got %h want %h", obs_vec(), exp_vec());
            end
            checks++;
        end
    endtask

    task automatic test_back_to_back;
        int k = 0;
        for (int i = 0; i < 12; i++) begin
            if (i < 8) do_cycle(1'b1, 1'b0, BASE + 32'(4 * i), 1'b1);
            else       do_cycle(1'b0, 1'b0, 32'd0, 1'b1);
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL b2b_cycle%0d: got %h want %h", i, obs_vec(), exp_vec());
            end
            checks++;
            if (i < 8 && obs_gnt !== 1'b1) begin
                errors++;
                $display("FAIL b2b_gnt%0d: got %b want 1", i, obs_gnt);
            end
            if (i < 8) checks++;
            if (obs_rvalid === 1'b1) begin
                if (obs_rdata !== 32'hC0DE0000 + 32'(k)) begin
                    errors++;
                    $display("FAIL b2b_order%0d: got %h want %h", k, obs_rdata,
                             32'hC0DE0000 + 32'(k));
                end
                checks++;
                k++;
            end
        end
        if (k !== 8) begin
            errors++;
            $display("FAIL b2b_count: got %0d responses want 8", k);
        end
        checks++;
    endtask

    task automatic test_backpressure;
        int grants = 0;
        int k = 0;
        for (int i = 0; i < 5; i++) begin
            do_cycle(1'b1, 1'b0, BASE + 32'(4 * (10 + i)), 1'b0);
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL bp_issue%0d: got %h want %h", i, obs_vec(), exp_vec());
            end
            checks++;
            if (obs_gnt === 1'b1) grants++;
        end
        if (grants !== 3) begin
            errors++;
            $display("FAIL bp_grants: got %0d want 3", grants);
        end
        checks++;
        for (int i = 0; i < 3; i++) begin
            do_cycle(1'b0, 1'b0, 32'd0, 1'b0);
            if (obs_rvalid !== 1'b1 || obs_rdata !== 32'hC0DE000A || obs_gnt !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d: got v=%b d=%h g=%b want v=1 d=c0de000a g=0",
                         i, obs_rvalid, obs_rdata, obs_gnt);
            end
            checks++;
        end
        for (int i = 0; i < 5; i++) begin
            do_cycle(1'b0, 1'b0, 32'd0, 1'b1);
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL bp_drain%0d: got %h want %h", i, obs_vec(), exp_vec());
            end
            checks++;
            if (obs_rvalid === 1'b1) begin
                if (obs_rdata !== 32'hC0DE000A + 32'(k)) begin
                    errors++;
                    $display("FAIL bp_order%0d: got %h want %h", k, obs_rdata,
                             32'hC0DE000A + 32'(k));
                end
                checks++;
                k++;
            end
        end
        if (k !== 3) begin
            errors++;
            $display("FAIL bp_count: got %0d responses want 3", k);
        end
        checks++;
        do_cycle(1'b1, 1'b0, BASE, 1'b1);
        if (obs_gnt !== 1'b1) begin
            errors++;
            $display("FAIL bp_resume: got gnt=%b want 1", obs_gnt);
        end
        checks++;
        repeat (4) do_cycle(1'b0, 1'b0, 32'd0, 1'b1);
    endtask

    task automatic test_errors;
        logic        ws [3] = '{1'b1, 1'b0, 1'b0};
        logic [31:0] as [3] = '{32'h1A00_0000, 32'h1A00_0200, 32'h19FF_FFFC};
        for (int t = 0; t < 3; t++) begin
            do_cycle(1'b1, ws[t], as[t], 1'b1);
            if (obs_cen !== 1'b1 || obs_gnt !== 1'b1) begin
                errors++;
                $display("FAIL err%0d_cen: got cen=%b gnt=%b want cen=1 gnt=1",
                         t, obs_cen, obs_gnt);
            end
            checks++;
            do_cycle(1'b0, 1'b0, 32'd0, 1'b1);
            do_cycle(1'b0, 1'b0, 32'd0, 1'b1);
            if (obs_rvalid !== 1'b1 || obs_err !== 1'b1 || obs_rdata !== 32'd0) begin
                errors++;
                $display("FAIL err%0d_resp: got v=%b e=%b d=%h want v=1 e=1 d=0",
                         t, obs_rvalid, obs_err, obs_rdata);
            end
            checks++;
            do_cycle(1'b0, 1'b0, 32'd0, 1'b1);
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL err%0d_after: got %h want %h", t, obs_vec(), exp_vec());
            end
            checks++;
        end
    endtask

    task automatic test_mixed;
        logic [32:0] want [3] = '{{32'hC0DE0002, 1'b0}, {32'd0, 1'b1}, {32'hC0DE0003, 1'b0}};
        int k = 0;
        for (int i = 0; i < 7; i++) begin
            case (i)
                0:       do_cycle(1'b1, 1'b0, BASE + 32'd8, 1'b1);
                1:       do_cycle(1'b1, 1'b1, BASE + 32'd8, 1'b1);
                2:       do_cycle(1'b1, 1'b0, BASE + 32'd12, 1'b1);
                default: do_cycle(1'b0, 1'b0, 32'd0, 1'b1);
            endcase
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL mixed_cycle%0d: got %h want %h", i, obs_vec(), exp_vec());
            end
            checks++;
            if (obs_rvalid === 1'b1 && k < 3) begin
                if ({obs_rdata, obs_err} !== want[k]) begin
                    errors++;
                    $display("FAIL mixed_order%0d: got %h/%b want %h", k, obs_rdata,
                             obs_err, want[k]);
                end
                checks++;
                k++;
            end
        end
        if (k !== 3) begin
            errors++;
            $display("FAIL mixed_count: got %0d want 3", k);
        end
        checks++;
    endtask

    task automatic test_reset_mid;
        int k = 0;
        for (int i = 0; i < 3; i++) do_cycle(1'b1, 1'b0, BASE + 32'(4 * (20 + i)), 1'b0);
        // Two responses buffered, one inflight.
        @(negedge clk);
        bus.req = 1'b0; bus.rready = 1'b1; rst_ni = 1'b0;
        #1;
        if (bus.rvalid !== 1'b0 || bus.rdata !== 32'd0 || bus.err !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_async: got v=%b d=%h e=%b want all 0",
                     bus.rvalid, bus.rdata, bus.err);
        end
        checks++;
        mq.delete();
        m_raddr = 7'd0;
        @(negedge clk);
        rst_ni = 1'b1;
        for (int i = 0; i < 4; i++) begin
            do_cycle(1'b0, 1'b0, 32'd0, 1'b1);
            if (obs_vec() !== exp_vec() || obs_rvalid !== 1'b0 || obs_gnt !== 1'b1) begin
                errors++;
                $display("FAIL rstmid_idle%0d: got %h want %h", i, obs_vec(), exp_vec());
            end
            checks++;
        end
        for (int i = 0; i < 5; i++) begin
            if (i == 0) do_cycle(1'b1, 1'b0, BASE + 32'd20, 1'b1);
            else        do_cycle(1'b0, 1'b0, 32'd0, 1'b1);
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL rstmid_next%0d: got %h want %h", i, obs_vec(), exp_vec());
            end
            checks++;
            if (obs_rvalid === 1'b1) begin
                if (obs_rdata !== 32'hC0DE0005 || obs_err !== 1'b0) begin
                    errors++;
                    $display("FAIL rstmid_data: got %h/%b want c0de0005/0", obs_rdata, obs_err);
                end
                checks++;
                k++;
            end
        end
        if (k !== 1) begin
            errors++;
            $display("FAIL rstmid_count: got %0d responses want 1", k);
        end
        checks++;
    endtask

    task automatic test_random;
        logic        r, w, rr;
        logic [31:0] a;
        for (int i = 0; i < 400; i++) begin
            r  = ($urandom % 4) != 0;
            w  = ($urandom % 8) == 0;
            rr = ($urandom % 4) != 0;
            case ($urandom % 8)
                0:       a = 32'h19FF_FFFC - 32'(4 * $urandom_range(0, 3));
                1:       a = BASE + 32'h200 + 32'(4 * $urandom_range(0, 64));
                default: a = BASE + 32'(4 * $urandom_range(0, 127)) + 32'($urandom_range(0, 3));
            endcase
            do_cycle(r, w, a, rr);
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random%0d: got %h want %h", i, obs_vec(), exp_vec());
            end
            checks++;
        end
        for (int i = 0; i < 6; i++) begin
            do_cycle(1'b0, 1'b0, 32'd0, 1'b1);
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random_drain%0d: got %h want %h", i, obs_vec(), exp_vec());
            end
            checks++;
        end
    endtask

    initial begin
        bus.req = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.rready = 1'b0;
        m_raddr = 7'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_ni = 1'b1;
        test_reset();
        test_single_read();
        test_back_to_back();
        test_backpressure();
        test_errors();
        test_mixed();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
